vm_change_dispenser: RTL and testbench

Payout unit on the output side of the vending machine. It accepts the machine's product/change (`pdt`, `cng`) and cancel-return (`rtn`) values and converts each amount owed into individual eject pulses on two coin hoppers, value 1 and value 2. Each ejected coin is confirmed by a hopper sensor. The unit also tracks hopper stock and flags payouts it cannot complete.

---
 rtl/vm_coin_pkg.sv | 23 ++
 rtl/vm_change_dispenser_if.sv | 33 +++
 rtl/vm_coin_stock.sv | 34 +++
 rtl/vm_change_dispenser.sv | 149 ++++++++++++++
 tb/tb_vm_change_dispenser.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_coin_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding and coin values.
package vm_coin_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEject,
    StWaitAck,
    StDone,
    StFault
  } disp_state_t;

  localparam logic [3:0] COIN1_VAL = 4'd1;
  localparam logic [3:0] COIN2_VAL = 4'd2;

  // Amount owed by a request; 4 bits so the 7 + 7 worst case cannot wrap.
  function automatic logic [3:0] req_amount(input logic       pdt,
                                            input logic [2:0] cng,
                                            input logic [2:0] rtn);
    return (pdt ? {1'b0, cng} : 4'd0) + {1'b0, rtn};
  endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Request, hopper-sensor and status signals between the vending controller and the dispenser.
interface vm_change_dispenser_if #(
  parameter int unsigned CNT_W = 4
);

  logic             pdt;
  logic [2:0]       cng;
  logic [2:0]       rtn;
  logic             coin_seen;
  logic             refill1;
  logic             refill2;
  logic             clr_fault;
  logic             eject1;
  logic             eject2;
  logic             busy;
  logic             done;
  logic             fault;
  logic             req_lost;
  logic [3:0]       owed;
  logic [CNT_W-1:0] stock1;
  logic [CNT_W-1:0] stock2;

  modport master (
    output pdt, cng, rtn, coin_seen, refill1, refill2, clr_fault,
    input  eject1, eject2, busy, done, fault, req_lost, owed, stock1, stock2
  );

  modport slave (
    input  pdt, cng, rtn, coin_seen, refill1, refill2, clr_fault,
    output eject1, eject2, busy, done, fault, req_lost, owed, stock1, stock2
  );

endinterface

// File: rtl/vm_coin_stock.sv
// Saturating up/down hopper stock counter; simultaneous inc and dec cancel out.
module vm_coin_stock #(
  parameter int unsigned INIT  = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MaxVal  = '1;
  localparam logic [CNT_W-1:0] InitVal = CNT_W'(INIT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != MaxVal) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= InitVal;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: converts owed amounts into greedy value-2/value-1 hopper ejects,
// waits for sensor confirmation of each coin and faults on shortage or sensor timeout.
module vm_change_dispenser
  import vm_coin_pkg::*;
#(
  parameter int unsigned C1_INIT = 8,
  parameter int unsigned C2_INIT = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  vm_change_dispenser_if.slave  bus
);

  localparam int unsigned   TmrW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  disp_state_t      state_q, state_d;
  logic [3:0]       owed_q, owed_d;
  logic [3:0]       req_prev_q;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic             sel2_q, sel2_d;
  logic             req_lost_q, req_lost_d;

  logic [3:0]       req_amt;
  logic             strobe;
  logic             dec1, dec2;
  logic [CNT_W-1:0] stock1, stock2;

  assign req_amt = req_amount(bus.pdt, bus.cng, bus.rtn);
  // Edge detect on the amount so a held request is served exactly once.
  assign strobe  = (req_amt != 4'd0) && (req_prev_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    owed_d     = owed_q;
    timer_d    = timer_q;
    sel2_d     = sel2_q;
    dec1       = 1'b0;
    dec2       = 1'b0;
    req_lost_d = strobe && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (strobe) begin
          owed_d  = req_amt;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (owed_q == 4'd0) begin
          state_d = StDone;
        end else if ((owed_q >= COIN2_VAL) && (stock2 != '0)) begin
          sel2_d  = 1'b1;
          state_d = StEject;
        end else if (stock1 != '0) begin
          sel2_d  = 1'b0;
          state_d = StEject;
        end else begin
          state_d = StFault;
        end
      end
      StEject: begin
        timer_d = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (bus.coin_seen) begin
          if (sel2_q) begin
            dec2   = 1'b1;
            owed_d = owed_q - COIN2_VAL;
          end else begin
            dec1   = 1'b1;
            owed_d = owed_q - COIN1_VAL;
          end
          state_d = StSelect;
        end else if (timer_q == TmrLast) begin
          state_d = StFault;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        if (bus.clr_fault) begin
          owed_d  = 4'd0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owed_q     <= 4'd0;
      req_prev_q <= 4'd0;
      timer_q    <= '0;
      sel2_q     <= 1'b0;
      req_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owed_q     <= owed_d;
      req_prev_q <= req_amt;
      timer_q    <= timer_d;
      sel2_q     <= sel2_d;
      req_lost_q <= req_lost_d;
    end
  end

  vm_coin_stock #(
    .INIT  (C1_INIT),
    .CNT_W (CNT_W)
  ) u_stock1 (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.refill1),
    .dec   (dec1),
    .count (stock1)
  );

  vm_coin_stock #(
    .INIT  (C2_INIT),
    .CNT_W (CNT_W)
  ) u_stock2 (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.refill2),
    .dec   (dec2),
    .count (stock2)
  );

  assign bus.eject1   = (state_q == StEject) && !sel2_q;
  assign bus.eject2   = (state_q == StEject) && sel2_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.fault    = (state_q == StFault);
  assign bus.req_lost = req_lost_q;
  assign bus.owed     = owed_q;
  assign bus.stock1   = stock1;
  assign bus.stock2   = stock2;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench: dut_a has 8/8 stock, dut_b has 8/0 stock; sel_b routes stimulus and outputs.
module tb_vm_change_dispenser;

  localparam int unsigned CntW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            sel_b;
  logic            pdt, coin_seen, refill1, refill2, clr_fault;
  logic [2:0]      cng, rtn;
  logic            eject1, eject2, busy, done, fault, req_lost;
  logic [3:0]      owed;
  logic [CntW-1:0] stock1, stock2;

  int n_tests = 0;
  int n_fail  = 0;

  vm_change_dispenser_if #(.CNT_W(CntW)) if_a ();
  vm_change_dispenser_if #(.CNT_W(CntW)) if_b ();

  vm_change_dispenser #(
    .C1_INIT (8),
    .C2_INIT (8),
    .CNT_W   (CntW),
    .TIMEOUT (15)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  vm_change_dispenser #(
    .C1_INIT (8),
    .C2_INIT (0),
    .CNT_W   (CntW),
    .TIMEOUT (15)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  assign if_a.pdt       = !sel_b && pdt;
  assign if_a.cng       = sel_b ? 3'd0 : cng;
  assign if_a.rtn       = sel_b ? 3'd0 : rtn;
  assign if_a.coin_seen = !sel_b && coin_seen;
  assign if_a.refill1   = !sel_b && refill1;
  assign if_a.refill2   = !sel_b && refill2;
  assign if_a.clr_fault = !sel_b && clr_fault;
  assign if_b.pdt       = sel_b && pdt;
  assign if_b.cng       = sel_b ? cng : 3'd0;
  assign if_b.rtn       = sel_b ? rtn : 3'd0;
  assign if_b.coin_seen = sel_b && coin_seen;
  assign if_b.refill1   = sel_b && refill1;
  assign if_b.refill2   = sel_b && refill2;
  assign if_b.clr_fault = sel_b && clr_fault;

  assign eject1   = sel_b ? if_b.eject1   : if_a.eject1;
  assign eject2   = sel_b ? if_b.eject2   : if_a.eject2;
  assign busy     = sel_b ? if_b.busy     : if_a.busy;
  assign done     = sel_b ? if_b.done     : if_a.done;
  assign fault    = sel_b ? if_b.fault    : if_a.fault;
  assign req_lost = sel_b ? if_b.req_lost : if_a.req_lost;
  assign owed     = sel_b ? if_b.owed     : if_a.owed;
  assign stock1   = sel_b ? if_b.stock1   : if_a.stock1;
  assign stock2   = sel_b ? if_b.stock2   : if_a.stock2;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a payout already set up on the inputs; the sensor answers ack_delay cycles after
  // each eject. With inject set, the first value-2 ack also carries refill2 and a new request.
  task automatic run_payout(input int ack_delay, input int budget, input bit inject,
                            output int n1, output int n2, output int nd, output int nl,
                            output int first_cyc, output bit first2, output bit ended);
    int  cd       = 0;
    bit  last2    = 1'b0;
    bit  injected = 1'b0;
    n1 = 0; n2 = 0; nd = 0; nl = 0; first_cyc = -1; first2 = 1'b0; ended = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      pdt = 1'b0; cng = 3'd0; rtn = 3'd0; coin_seen = 1'b0; refill2 = 1'b0;
      if (eject1) n1++;
      if (eject2) n2++;
      if (done) nd++;
      if (req_lost) nl++;
      if ((eject1 || eject2) && first_cyc < 0) begin
        first_cyc = c;
        first2    = eject2;
      end
      if (eject1 || eject2) begin
        cd    = ack_delay;
        last2 = eject2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          coin_seen = 1'b1;
          if (inject && last2 && !injected) begin
            refill2  = 1'b1;
            rtn      = 3'd1;
            injected = 1'b1;
          end
        end
      end
      if (done || fault) begin
        ended = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, nd, nl, fc, fault_cyc, ej;
    bit f2, ended;

    rst = 1'b1; sel_b = 1'b0;
    pdt = 1'b0; cng = 3'd0; rtn = 3'd0; coin_seen = 1'b0;
    refill1 = 1'b0; refill2 = 1'b0; clr_fault = 1'b0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owed", owed, 0);
    check_eq("rst_pulses", {eject1, eject2, done, fault, req_lost}, 0);
    check_eq("rst_stock1", stock1, 8);
    check_eq("rst_stock2", stock2, 8);
    sel_b = 1'b1; #1;
    check_eq("rst_b_stock2", stock2, 0);
    sel_b = 1'b0;

    // Zero-amount request must not start anything.
    pdt = 1'b1; cng = 3'd0;
    step(); step(); step();
    check_eq("zero_req_busy", busy, 0);
    pdt = 1'b0;
    step();

    // cng=3: value-2 coin then value-1 coin.
    pdt = 1'b1; cng = 3'd3;
    run_payout(2, 60, 1'b0, n1, n2, nd, nl, fc, f2, ended);
    check_eq("t1_ended", ended, 1);
    check_eq("t1_first_eject_cyc", fc, 1);
    check_eq("t1_first_is_2", f2, 1);
    check_eq("t1_n_eject2", n2, 1);
    check_eq("t1_n_eject1", n1, 1);
    check_eq("t1_n_done", nd, 1);
    check_eq("t1_owed", owed, 0);
    check_eq("t1_stock1", stock1, 7);
    check_eq("t1_stock2", stock2, 7);
    step();
    check_eq("t1_idle", busy, 0);

    // Held cng=2 with no sensor: timeout fault.
    pdt = 1'b1; cng = 3'd2;
    fault_cyc = 0; ej = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (eject2) ej++;
      if (fault) begin
        fault_cyc = c;
        break;
      end
    end
    check_eq("t4_fault_cycle", fault_cyc, 18);
    check_eq("t4_n_eject2", ej, 1);
    check_eq("t4_owed", owed, 2);
    check_eq("t4_stock2", stock2, 7);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    check_eq("t4_clr_fault", fault, 0);
    check_eq("t4_clr_owed", owed, 0);
    step(); step();
    check_eq("t4_held_no_restart", busy, 0);
    pdt = 1'b0; cng = 3'd0;
    step();

    // Refill2 with value-2 ack, plus a lost request.
    pdt = 1'b1; cng = 3'd3;
    run_payout(2, 60, 1'b1, n1, n2, nd, nl, fc, f2, ended);
    check_eq("t5_ended", ended, 1);
    check_eq("t5_n_eject2", n2, 1);
    check_eq("t5_n_eject1", n1, 1);
    check_eq("t5_n_done", nd, 1);
    check_eq("t5_req_lost", nl, 1);
    check_eq("t5_stock2", stock2, 7);
    check_eq("t5_stock1", stock1, 6);
    step(); step(); step();
    check_eq("t5_no_restart", busy, 0);

    // dut_b: no value-2 stock.
    sel_b = 1'b1;
    rtn = 3'd5;
    run_payout(2, 80, 1'b0, n1, n2, nd, nl, fc, f2, ended);
    check_eq("t2_n_eject1", n1, 5);
    check_eq("t2_n_eject2", n2, 0);
    check_eq("t2_n_done", nd, 1);
    check_eq("t2_stock1", stock1, 3);
    step();
    rtn = 3'd3;
    run_payout(2, 80, 1'b0, n1, n2, nd, nl, fc, f2, ended);
    check_eq("t3_drain_n1", n1, 3);
    check_eq("t3_drain_stock1", stock1, 0);
    step();
    refill2 = 1'b1;
    step(); step();
    refill2 = 1'b0;
    step();
    check_eq("t3_refill_stock2", stock2, 2);
    rtn = 3'd5;
    run_payout(2, 80, 1'b0, n1, n2, nd, nl, fc, f2, ended);
    check_eq("t3_ended", ended, 1);
    check_eq("t3_n_eject2", n2, 2);
    check_eq("t3_n_eject1", n1, 0);
    check_eq("t3_no_done", nd, 0);
    check_eq("t3_fault", fault, 1);
    check_eq("t3_owed", owed, 1);
    step(); step();
    check_eq("t3_fault_holds", fault, 1);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    check_eq("t3_clr_busy", busy, 0);
    check_eq("t3_clr_owed", owed, 0);
    sel_b = 1'b0;

    // Reset during WAIT_ACK on dut_a.
    rtn = 3'd2;
    step();
    rtn = 3'd0;
    step();
    check_eq("t6_eject2", eject2, 1);
    step();
    check_eq("t6_waiting", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_owed", owed, 0);
    check_eq("t6_stock1", stock1, 8);
    check_eq("t6_stock2", stock2, 8);
    ej = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (eject1 || eject2 || done) ej++;
    end
    check_eq("t6_quiet_after_rst", ej, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
